// File: rtl/reg_file.sv
// LEGv8 integer register file: two combinational read ports, one clocked write port,
// same-cycle write-to-read bypass, top index hardwired to zero (XZR).
module reg_file #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned           NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR_IDX   = ADDR_WIDTH'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_wr_en;
  logic                  w_byp1;
  logic                  w_byp2;

  // Writes to XZR and writes under reset are dropped; the same qualifier gates bypass.
  assign w_wr_en = reg_write && !reset && (write_reg != ZR_IDX);
  assign w_byp1  = w_wr_en && (write_reg == read_reg1);
  assign w_byp2  = w_wr_en && (write_reg == read_reg2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Read muxes: reset and XZR force zero ahead of bypass and array contents.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (!reset) begin
      if (read_reg1 == ZR_IDX)  read_data1 = '0;
      else if (w_byp1)          read_data1 = write_data;
      else                      read_data1 = r_regs[read_reg1];

      if (read_reg2 == ZR_IDX)  read_data2 = '0;
      else if (w_byp2)          read_data2 = write_data;
      else                      read_data2 = r_regs[read_reg2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read values, a monitor
// process pops and compares them when a sample strobe fires.
module tb_reg_file;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic [AW-1:0] read_reg1;
  logic [AW-1:0] read_reg2;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          reg_write;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];
  event ev_sample;
  int   n_cmp = 0;
  int   n_err = 0;

  // Monitor: drain every pending expectation against the port it names.
  initial begin
    exp_t          e;
    logic [DW-1:0] act;
    forever begin
      @(ev_sample);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = (e.port == 1) ? read_data1 : read_data2;
        n_cmp++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
        end
      end
    end
  end

  task automatic expect_rd(input string name, input int port, input logic [DW-1:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sample();
    #1;
    ->ev_sample;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = data;
    tick();
    reg_write  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] pat;
    logic [DW-1:0] walk;

    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd5; read_reg2 = 5'd31;
    #2;
    expect_rd("reset_state", 1, '0);
    expect_rd("reset_state", 2, '0);
    sample();
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-run clears X5 without a clock edge.
    wr(5'd5, 64'hDEAD);
    read_reg1 = 5'd5;
    expect_rd("x5_written", 1, 64'hDEAD);
    sample();
    reset = 1'b1;
    expect_rd("async_reset_clear", 1, '0);
    sample();
    reg_write = 1'b1; write_reg = 5'd5; write_data = 64'hBEEF;
    expect_rd("reset_bypass_suppressed", 1, '0);
    sample();
    tick();
    expect_rd("reset_write_suppressed", 1, '0);
    sample();
    reg_write = 1'b0;
    reset = 1'b0;
    expect_rd("after_release", 1, '0);
    sample();
    tick();
    expect_rd("after_release_edge", 1, '0);
    sample();

    // Fill X0..X30 and read mirrored pairs.
    for (int i = 0; i < 31; i++) begin
      pat = DW'(i) * 64'h0101_0101_0101_0101;
      wr(AW'(i), pat);
    end
    for (int i = 0; i < 31; i++) begin
      read_reg1 = AW'(i);
      read_reg2 = AW'(30 - i);
      expect_rd("pair_read", 1, DW'(i) * 64'h0101_0101_0101_0101);
      expect_rd("pair_read", 2, DW'(30 - i) * 64'h0101_0101_0101_0101);
      sample();
      tick();
    end

    // XZR discards writes and never bypasses.
    reg_write = 1'b1; write_reg = 5'd31; write_data = '1;
    read_reg1 = 5'd31; read_reg2 = 5'd31;
    expect_rd("xzr_same_cycle", 1, '0);
    expect_rd("xzr_same_cycle", 2, '0);
    sample();
    tick();
    reg_write = 1'b0;
    expect_rd("xzr_after_edge", 1, '0);
    expect_rd("xzr_after_edge", 2, '0);
    sample();

    // Same-cycle bypass on both ports, then committed value.
    wr(5'd7, 64'h1111);
    read_reg1 = 5'd7; read_reg2 = 5'd7;
    expect_rd("x7_before", 1, 64'h1111);
    sample();
    reg_write = 1'b1; write_reg = 5'd7; write_data = 64'h2222;
    expect_rd("bypass_p1", 1, 64'h2222);
    expect_rd("bypass_p2", 2, 64'h2222);
    sample();
    tick();
    reg_write = 1'b0;
    expect_rd("bypass_committed", 1, 64'h2222);
    sample();

    // No write enable: neither write nor bypass.
    wr(5'd9, 64'h42);
    reg_write = 1'b0; write_reg = 5'd9; write_data = 64'hFFFF; read_reg2 = 5'd9;
    expect_rd("no_we_before", 2, 64'h42);
    sample();
    tick();
    expect_rd("no_we_after", 2, 64'h42);
    sample();

    // Walking one through X12.
    read_reg1 = 5'd12;
    for (int i = 0; i < int'(DW); i++) begin
      walk = DW'(1) << i;
      wr(5'd12, walk);
      expect_rd("walking_one", 1, walk);
      sample();
    end

    #5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
